// File: rtl/uart_io_rst_pkg.sv
// Shared definitions for the UART/IO PLL reset sequencer.
// Holds the sequencer state encoding, the default parameter values used by
// uart_io_pll_reset_seq, and a helper that sizes a counter so it can hold a
// given maximum value without wrapping.
package uart_io_rst_pkg;

  // Default sequencing parameters (cycles of the 50 MHz reference clock)
  localparam int DEF_PLL_RST_CYCLES      = 16;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 500000;
  localparam int DEF_MAX_RETRIES         = 3;
  localparam int DEF_RELEASE_GAP         = 8;
  localparam int DEF_LOSS_W              = 8;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } rstState_e;

  // Width needed to hold values 0..maxVal; never narrower than one bit
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/uart_io_sync2.sv
// Two-flop bit synchronizer for bringing an asynchronous level into clk_i.
// Ports:
//   clk_i  - destination clock
//   rstN_i - synchronous active-low reset, clears both flops
//   d_i    - asynchronous input level
//   q_o    - synchronized level, two cycles of latency
module uart_io_sync2 (
  input  logic clk_i,
  input  logic rstN_i,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic meta_q;
  (* ASYNC_REG = "TRUE" *) logic sync_q;

  // First flop may go metastable; the second gives it a full cycle to settle
  always_ff @(posedge clk_i) begin
    if (!rstN_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_io_pll_reset_seq.sv
// PLL-gated reset sequencer for the UART and IO domain.
// Pulses the PLL reset, waits for a stable lock, releases the core reset,
// then after a short gap the peripheral reset. Retries on lock timeout,
// gives up into FAIL, and restarts on lock loss or software request.
// Ports:
//   clk            - 50 MHz reference clock (also the PLL refclk)
//   reset_n        - synchronous active-low reset
//   pll_locked     - PLL lock, asynchronous to clk
//   sw_reset_req   - single-cycle request to restart the sequence
//   pll_rst        - PLL reset, active-high
//   sys_reset_n    - core system reset, active-low
//   periph_reset_n - UART/IO peripheral reset, active-low
//   ready          - high only in RUN
//   fail           - high only in FAIL
//   lock_loss_cnt  - saturating count of lock losses seen in RUN
module uart_io_pll_reset_seq
  import uart_io_rst_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int RELEASE_GAP         = DEF_RELEASE_GAP,
  parameter int LOSS_W              = DEF_LOSS_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pll_locked,
  input  logic              sw_reset_req,
  output logic              pll_rst,
  output logic              sys_reset_n,
  output logic              periph_reset_n,
  output logic              ready,
  output logic              fail,
  output logic [LOSS_W-1:0] lock_loss_cnt
);

  localparam int RST_W   = cntWidth(PLL_RST_CYCLES);
  localparam int STB_W   = cntWidth(LOCK_STABLE_CYCLES);
  localparam int TMO_W   = cntWidth(LOCK_TIMEOUT_CYCLES);
  localparam int RETRY_W = cntWidth(MAX_RETRIES);
  localparam int GAP_W   = cntWidth(RELEASE_GAP);

  rstState_e           state_q, state_d;
  logic [RST_W-1:0]    rstCnt_q, rstCnt_d;
  logic [STB_W-1:0]    stableCnt_q, stableCnt_d;
  logic [TMO_W-1:0]    tmoCnt_q, tmoCnt_d;
  logic [RETRY_W-1:0]  retryCnt_q, retryCnt_d;
  logic [GAP_W-1:0]    gapCnt_q, gapCnt_d;
  logic [LOSS_W-1:0]   lossCnt_q, lossCnt_d;
  logic                pllRst_q, pllRst_d;
  logic                sysRstN_q, sysRstN_d;
  logic                perRstN_q, perRstN_d;
  logic                ready_q, ready_d;
  logic                fail_q, fail_d;

  logic lockedSync;
  logic timeoutHit;
  logic takeTimeout;
  logic stableDone;
  logic lockWindow_q, lockWindow_d;

  uart_io_sync2 u_lockSync (
    .clk_i  (clk),
    .rstN_i (reset_n),
    .d_i    (pll_locked),
    .q_o    (lockedSync)
  );

  assign timeoutHit = (tmoCnt_q == TMO_W'(LOCK_TIMEOUT_CYCLES - 1));
  // The entry cycle clears the count, so release comes after the counter has
  // climbed all the way to LOCK_STABLE_CYCLES on uninterrupted lock
  assign stableDone = (stableCnt_q == STB_W'(LOCK_STABLE_CYCLES));
  assign lockWindow_q = (state_q == ST_WAIT_LOCK) || (state_q == ST_STABLE);
  assign lockWindow_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE);

  // Next-state, counter and output decode. Software restart beats everything;
  // in STABLE a completed lock window beats a simultaneous timeout.
  always_comb begin
    state_d     = state_q;
    retryCnt_d  = retryCnt_q;
    lossCnt_d   = lossCnt_q;
    takeTimeout = 1'b0;

    if (sw_reset_req) begin
      state_d    = ST_PLL_RST;
      retryCnt_d = '0;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (rstCnt_q == RST_W'(PLL_RST_CYCLES - 1)) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (timeoutHit)      takeTimeout = 1'b1;
          else if (lockedSync) state_d = ST_STABLE;
        end
        ST_STABLE: begin
          if (lockedSync && stableDone) state_d = ST_RELEASE;
          else if (timeoutHit)          takeTimeout = 1'b1;
          else if (!lockedSync)         state_d = ST_WAIT_LOCK;
        end
        ST_RELEASE: begin
          if (!lockedSync)                                state_d = ST_PLL_RST;
          else if (gapCnt_q == GAP_W'(RELEASE_GAP - 1))   state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!lockedSync) begin
            state_d    = ST_PLL_RST;
            retryCnt_d = '0;
            if (lossCnt_q != {LOSS_W{1'b1}}) lossCnt_d = lossCnt_q + 1'b1;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_PLL_RST;
        end
      endcase

      if (takeTimeout) begin
        if (retryCnt_q < RETRY_W'(MAX_RETRIES)) begin
          retryCnt_d = retryCnt_q + 1'b1;
          state_d    = ST_PLL_RST;
        end else begin
          state_d = ST_FAIL;
        end
      end
    end

    // Each counter only runs while its state persists and restarts on entry
    rstCnt_d    = (state_q == ST_PLL_RST && state_d == ST_PLL_RST && !sw_reset_req)
                  ? rstCnt_q + 1'b1 : '0;
    stableCnt_d = (state_q == ST_STABLE && state_d == ST_STABLE)
                  ? stableCnt_q + 1'b1 : '0;
    gapCnt_d    = (state_q == ST_RELEASE && state_d == ST_RELEASE)
                  ? gapCnt_q + 1'b1 : '0;
    // Timeout spans WAIT_LOCK and STABLE together so lock chatter cannot reset it
    tmoCnt_d    = (lockWindow_q && lockWindow_d) ? tmoCnt_q + 1'b1 : '0;

    // Outputs are decoded from the next state so they change on the transition
    pllRst_d  = (state_d == ST_PLL_RST);
    sysRstN_d = (state_d == ST_RELEASE) || (state_d == ST_RUN);
    perRstN_d = (state_d == ST_RUN);
    ready_d   = (state_d == ST_RUN);
    fail_d    = (state_d == ST_FAIL);
  end

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_PLL_RST;
      rstCnt_q    <= '0;
      stableCnt_q <= '0;
      tmoCnt_q    <= '0;
      retryCnt_q  <= '0;
      gapCnt_q    <= '0;
      lossCnt_q   <= '0;
      pllRst_q    <= 1'b1;
      sysRstN_q   <= 1'b0;
      perRstN_q   <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rstCnt_q    <= rstCnt_d;
      stableCnt_q <= stableCnt_d;
      tmoCnt_q    <= tmoCnt_d;
      retryCnt_q  <= retryCnt_d;
      gapCnt_q    <= gapCnt_d;
      lossCnt_q   <= lossCnt_d;
      pllRst_q    <= pllRst_d;
      sysRstN_q   <= sysRstN_d;
      perRstN_q   <= perRstN_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_rst        = pllRst_q;
  assign sys_reset_n    = sysRstN_q;
  assign periph_reset_n = perRstN_q;
  assign ready          = ready_q;
  assign fail           = fail_q;
  assign lock_loss_cnt  = lossCnt_q;

endmodule

// File: tb/tb_uart_io_pll_reset_seq.sv
// Directed testbench for uart_io_pll_reset_seq with shortened timing:
// PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=64,
// MAX_RETRIES=2, RELEASE_GAP=3.
// Expected cycle positions, counted in clock edges from the sample where the
// sequencer sits in PLL_RST with a cleared counter and lock already visible:
//   pll_rst falls at 4, sys_reset_n rises at 14 (1 WAIT_LOCK + 9 STABLE),
//   periph_reset_n and ready rise at 17.
module tb_uart_io_pll_reset_seq;

  logic       clk;
  logic       reset_n;
  logic       pll_locked;
  logic       sw_reset_req;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       periph_reset_n;
  logic       ready;
  logic       fail;
  logic [7:0] lock_loss_cnt;

  int checks;
  int failures;

  uart_io_pll_reset_seq #(
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (64),
    .MAX_RETRIES         (2),
    .RELEASE_GAP         (3),
    .LOSS_W              (8)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pll_locked     (pll_locked),
    .sw_reset_req   (sw_reset_req),
    .pll_rst        (pll_rst),
    .sys_reset_n    (sys_reset_n),
    .periph_reset_n (periph_reset_n),
    .ready          (ready),
    .fail           (fail),
    .lock_loss_cnt  (lock_loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sampling and driving happen 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for three edges and release it just after the last one
  task automatic doReset();
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
  endtask

  // Record the edge index of the first pll_rst low, sys/periph/ready high,
  // and count cycles where periph_reset_n is high while sys_reset_n is low.
  // Index 0 is the current sample; -1 means the event never happened.
  task automatic measure(input int limit, output int fallI, output int sysI,
                         output int perI, output int rdyI, output int orderBad);
    fallI = -1; sysI = -1; perI = -1; rdyI = -1; orderBad = 0;
    for (int i = 0; i <= limit; i++) begin
      if (i > 0) step();
      if (fallI < 0 && pll_rst == 1'b0)     fallI = i;
      if (sysI < 0 && sys_reset_n == 1'b1)  sysI = i;
      if (perI < 0 && periph_reset_n == 1'b1) perI = i;
      if (rdyI < 0 && ready == 1'b1)        rdyI = i;
      if (periph_reset_n && !sys_reset_n)   orderBad++;
      if (rdyI >= 0) break;
    end
  endtask

  task automatic test_reset();
    pll_locked   = 1'b1;
    sw_reset_req = 1'b0;
    reset_n      = 1'b0;
    repeat (3) step();
    checks += 6;
    if (pll_rst !== 1'b1) begin failures++; $display("[TB] FAIL reset_pll_rst: got %b expected 1", pll_rst); end
    if (sys_reset_n !== 1'b0) begin failures++; $display("[TB] FAIL reset_sys: got %b expected 0", sys_reset_n); end
    if (periph_reset_n !== 1'b0) begin failures++; $display("[TB] FAIL reset_periph: got %b expected 0", periph_reset_n); end
    if (ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
    if (fail !== 1'b0) begin failures++; $display("[TB] FAIL reset_fail: got %b expected 0", fail); end
    if (lock_loss_cnt !== 8'd0) begin failures++; $display("[TB] FAIL reset_loss: got %0d expected 0", lock_loss_cnt); end
  endtask

  task automatic test_nominal();
    int fallI, sysI, perI, rdyI, bad;
    pll_locked = 1'b1;
    doReset();
    measure(60, fallI, sysI, perI, rdyI, bad);
    checks += 6;
    if (fallI !== 4) begin failures++; $display("[TB] FAIL nominal_pll_rst_len: got %0d expected 4", fallI); end
    if (sysI - fallI !== 10) begin failures++; $display("[TB] FAIL nominal_sys_after_pll: got %0d expected 10", sysI - fallI); end
    if (perI - sysI !== 3) begin failures++; $display("[TB] FAIL nominal_periph_gap: got %0d expected 3", perI - sysI); end
    if (rdyI !== 17) begin failures++; $display("[TB] FAIL nominal_ready: got %0d expected 17", rdyI); end
    if (bad !== 0) begin failures++; $display("[TB] FAIL nominal_order: got %0d expected 0", bad); end
    if (fail !== 1'b0) begin failures++; $display("[TB] FAIL nominal_fail: got %b expected 0", fail); end
  endtask

  // Lock loss and software restart land on the same edge; restart must win
  task automatic test_sw_priority();
    int fallI, sysI, perI, rdyI, bad;
    pll_locked = 1'b0;
    step();
    step();
    sw_reset_req = 1'b1;
    step();
    sw_reset_req = 1'b0;
    pll_locked   = 1'b1;
    checks += 3;
    if (lock_loss_cnt !== 8'd0) begin failures++; $display("[TB] FAIL swprio_loss: got %0d expected 0", lock_loss_cnt); end
    if (pll_rst !== 1'b1) begin failures++; $display("[TB] FAIL swprio_pll_rst: got %b expected 1", pll_rst); end
    measure(40, fallI, sysI, perI, rdyI, bad);
    if (rdyI !== 17) begin failures++; $display("[TB] FAIL swprio_ready: got %0d expected 17", rdyI); end
  endtask

  task automatic test_glitch();
    int fallI, sysI, perI, rdyI, bad;
    pll_locked = 1'b0;
    doReset();
    repeat (4) step();
    checks += 3;
    if (pll_rst !== 1'b0) begin failures++; $display("[TB] FAIL glitch_pll_rst: got %b expected 0", pll_rst); end
    pll_locked = 1'b1;
    repeat (5) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    measure(40, fallI, sysI, perI, rdyI, bad);
    if (sysI !== 12) begin failures++; $display("[TB] FAIL glitch_sys_rise: got %0d expected 12", sysI); end
    if (perI !== 15) begin failures++; $display("[TB] FAIL glitch_periph_rise: got %0d expected 15", perI); end
  endtask

  task automatic test_no_lock();
    int fallIdx[3];
    int riseIdx[2];
    int nFall, nRise, failIdx;
    logic prevRst;
    for (int k = 0; k < 3; k++) fallIdx[k] = -1;
    for (int k = 0; k < 2; k++) riseIdx[k] = -1;
    nFall = 0; nRise = 0; failIdx = -1;
    pll_locked = 1'b0;
    doReset();
    prevRst = pll_rst;
    for (int i = 1; i <= 260; i++) begin
      step();
      if (prevRst && !pll_rst) begin
        if (nFall < 3) fallIdx[nFall] = i;
        nFall++;
      end
      if (!prevRst && pll_rst) begin
        if (nRise < 2) riseIdx[nRise] = i;
        nRise++;
      end
      if (failIdx < 0 && fail) failIdx = i;
      prevRst = pll_rst;
    end
    checks += 11;
    if (nFall !== 3) begin failures++; $display("[TB] FAIL nolock_pulses: got %0d expected 3", nFall); end
    if (nRise !== 2) begin failures++; $display("[TB] FAIL nolock_rises: got %0d expected 2", nRise); end
    if (fallIdx[0] !== 4) begin failures++; $display("[TB] FAIL nolock_first_fall: got %0d expected 4", fallIdx[0]); end
    if (riseIdx[0] - fallIdx[0] !== 64) begin failures++; $display("[TB] FAIL nolock_gap1: got %0d expected 64", riseIdx[0] - fallIdx[0]); end
    if (riseIdx[1] - fallIdx[1] !== 64) begin failures++; $display("[TB] FAIL nolock_gap2: got %0d expected 64", riseIdx[1] - fallIdx[1]); end
    if (fallIdx[2] !== 140) begin failures++; $display("[TB] FAIL nolock_third_fall: got %0d expected 140", fallIdx[2]); end
    if (failIdx !== 204) begin failures++; $display("[TB] FAIL nolock_fail_time: got %0d expected 204", failIdx); end
    if (fail !== 1'b1) begin failures++; $display("[TB] FAIL nolock_fail_hold: got %b expected 1", fail); end
    if (pll_rst !== 1'b0) begin failures++; $display("[TB] FAIL nolock_pll_rst: got %b expected 0", pll_rst); end
    if (sys_reset_n !== 1'b0) begin failures++; $display("[TB] FAIL nolock_sys: got %b expected 0", sys_reset_n); end
    if (periph_reset_n !== 1'b0 || ready !== 1'b0) begin failures++; $display("[TB] FAIL nolock_periph_ready: got %b%b expected 00", periph_reset_n, ready); end
  endtask

  task automatic test_recovery();
    int fallI, sysI, perI, rdyI, bad;
    pll_locked = 1'b1;
    repeat (3) step();
    sw_reset_req = 1'b1;
    step();
    sw_reset_req = 1'b0;
    checks += 5;
    if (fail !== 1'b0) begin failures++; $display("[TB] FAIL recover_fail: got %b expected 0", fail); end
    if (pll_rst !== 1'b1) begin failures++; $display("[TB] FAIL recover_pll_rst: got %b expected 1", pll_rst); end
    measure(40, fallI, sysI, perI, rdyI, bad);
    if (fallI !== 4) begin failures++; $display("[TB] FAIL recover_pll_fall: got %0d expected 4", fallI); end
    if (sysI !== 14) begin failures++; $display("[TB] FAIL recover_sys: got %0d expected 14", sysI); end
    if (rdyI !== 17) begin failures++; $display("[TB] FAIL recover_ready: got %0d expected 17", rdyI); end
  endtask

  task automatic test_lock_loss();
    int fallI, sysI, perI, rdyI, bad, lowIdx, expLoss;
    for (int it = 1; it <= 300; it++) begin
      expLoss = (it > 255) ? 255 : it;
      pll_locked = 1'b0;
      lowIdx = -1;
      for (int i = 1; i <= 4; i++) begin
        step();
        if (!sys_reset_n && !periph_reset_n && !ready) begin
          lowIdx = i;
          break;
        end
      end
      checks += 3;
      if (lowIdx < 0) begin failures++; $display("[TB] FAIL loss_resets_low it=%0d: got none within 4 expected <=4", it); end
      if (lock_loss_cnt !== expLoss[7:0]) begin failures++; $display("[TB] FAIL loss_count it=%0d: got %0d expected %0d", it, lock_loss_cnt, expLoss); end
      pll_locked = 1'b1;
      measure(40, fallI, sysI, perI, rdyI, bad);
      if (rdyI < 0) begin failures++; $display("[TB] FAIL loss_rerun it=%0d: got no ready expected ready", it); end
    end
    checks++;
    if (lock_loss_cnt !== 8'd255) begin failures++; $display("[TB] FAIL loss_saturate: got %0d expected 255", lock_loss_cnt); end
  endtask

  task automatic test_reset_in_run();
    int fallI, sysI, perI, rdyI, bad;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    checks += 9;
    if (pll_rst !== 1'b1) begin failures++; $display("[TB] FAIL rrun_pll_rst: got %b expected 1", pll_rst); end
    if (sys_reset_n !== 1'b0) begin failures++; $display("[TB] FAIL rrun_sys: got %b expected 0", sys_reset_n); end
    if (periph_reset_n !== 1'b0) begin failures++; $display("[TB] FAIL rrun_periph: got %b expected 0", periph_reset_n); end
    if (ready !== 1'b0) begin failures++; $display("[TB] FAIL rrun_ready: got %b expected 0", ready); end
    if (fail !== 1'b0) begin failures++; $display("[TB] FAIL rrun_fail: got %b expected 0", fail); end
    if (lock_loss_cnt !== 8'd0) begin failures++; $display("[TB] FAIL rrun_loss: got %0d expected 0", lock_loss_cnt); end
    measure(60, fallI, sysI, perI, rdyI, bad);
    if (fallI !== 4) begin failures++; $display("[TB] FAIL rrun_pll_fall: got %0d expected 4", fallI); end
    if (sysI !== 14) begin failures++; $display("[TB] FAIL rrun_sys_rise: got %0d expected 14", sysI); end
    if (perI !== 17 || rdyI !== 17) begin failures++; $display("[TB] FAIL rrun_periph_ready: got %0d/%0d expected 17/17", perI, rdyI); end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset_n      = 1'b0;
    pll_locked   = 1'b0;
    sw_reset_req = 1'b0;
    test_reset();
    test_nominal();
    test_sw_priority();
    test_glitch();
    test_no_lock();
    test_recovery();
    test_lock_loss();
    test_reset_in_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
